db_lcu_scheduler: RTL and testbench

Frame-level scheduler that sits above the deblocking top controller and sequences it across a picture, one LCU at a time. It samples the picture size in LCUs at frame start and waits until upstream has an LCU buffered and the output path is free. It then issues a one-cycle start to the deblocking core and waits for its done pulse. It maintains LCU x/y coordinates and boundary flags for the filters and signals end of frame.

---
 rtl/db_lcu_scheduler.sv | 108 ++++++++++
 tb/tb_db_lcu_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/db_lcu_scheduler.sv
// rtl/db_lcu_scheduler.sv - frame-level LCU sequencer above the deblocking core
module db_lcu_scheduler #(
    parameter int LCU_AW = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sys_start_i,
    input  logic [LCU_AW-1:0]     pic_w_lcu_i,
    input  logic [LCU_AW-1:0]     pic_h_lcu_i,
    input  logic                  lcu_rdy_i,
    output logic                  lcu_ack_o,
    input  logic                  out_busy_i,
    output logic                  db_start_o,
    input  logic                  db_done_i,
    output logic [LCU_AW-1:0]     lcu_x_o,
    output logic [LCU_AW-1:0]     lcu_y_o,
    output logic                  lcu_left_o,
    output logic                  lcu_top_o,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic [2*LCU_AW-1:0]   lcu_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [LCU_AW-1:0]   ONE_C = LCU_AW'(1);
    localparam logic [2*LCU_AW-1:0] ONE_N = (2*LCU_AW)'(1);

    state_t                state;
    logic [LCU_AW-1:0]     w_q;
    logic [LCU_AW-1:0]     h_q;
    logic [LCU_AW-1:0]     x_q;
    logic [LCU_AW-1:0]     y_q;
    logic [2*LCU_AW-1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            w_q   <= '0;
            h_q   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sys_start_i) begin
                        w_q   <= pic_w_lcu_i;
                        h_q   <= pic_h_lcu_i;
                        x_q   <= '0;
                        y_q   <= '0;
                        cnt_q <= '0;
                        // An empty picture still reports frame completion.
                        if (pic_w_lcu_i == '0 || pic_h_lcu_i == '0)
                            state <= S_DONE;
                        else
                            state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lcu_rdy_i && !out_busy_i)
                        state <= S_START;
                end
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (db_done_i)
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    cnt_q <= cnt_q + ONE_N;
                    if (x_q == w_q - ONE_C) begin
                        if (y_q == h_q - ONE_C) begin
                            state <= S_DONE;
                        end else begin
                            x_q   <= '0;
                            y_q   <= y_q + ONE_C;
                            state <= S_WAIT;
                        end
                    end else begin
                        x_q   <= x_q + ONE_C;
                        state <= S_WAIT;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs decode the state register only, never the inputs.
    assign db_start_o   = (state == S_START);
    assign lcu_ack_o    = (state == S_START);
    assign frame_done_o = (state == S_DONE);
    assign busy_o       = (state != S_IDLE);
    assign lcu_x_o      = x_q;
    assign lcu_y_o      = y_q;
    assign lcu_left_o   = (x_q == '0);
    assign lcu_top_o    = (y_q == '0);
    assign lcu_cnt_o    = cnt_q;

endmodule

// File: tb/tb_db_lcu_scheduler.sv
// tb/tb_db_lcu_scheduler.sv - randomized check of db_lcu_scheduler against a frame-level model
module tb_db_lcu_scheduler;

    localparam int LCU_AW = 7;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                sys_start_i = 1'b0;
    logic [LCU_AW-1:0]   pic_w_lcu_i = '0;
    logic [LCU_AW-1:0]   pic_h_lcu_i = '0;
    logic                lcu_rdy_i = 1'b0;
    logic                lcu_ack_o;
    logic                out_busy_i = 1'b0;
    logic                db_start_o;
    logic                db_done_i = 1'b0;
    logic [LCU_AW-1:0]   lcu_x_o;
    logic [LCU_AW-1:0]   lcu_y_o;
    logic                lcu_left_o;
    logic                lcu_top_o;
    logic                busy_o;
    logic                frame_done_o;
    logic [2*LCU_AW-1:0] lcu_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    db_lcu_scheduler #(.LCU_AW(LCU_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sys_start_i  (sys_start_i),
        .pic_w_lcu_i  (pic_w_lcu_i),
        .pic_h_lcu_i  (pic_h_lcu_i),
        .lcu_rdy_i    (lcu_rdy_i),
        .lcu_ack_o    (lcu_ack_o),
        .out_busy_i   (out_busy_i),
        .db_start_o   (db_start_o),
        .db_done_i    (db_done_i),
        .lcu_x_o      (lcu_x_o),
        .lcu_y_o      (lcu_y_o),
        .lcu_left_o   (lcu_left_o),
        .lcu_top_o    (lcu_top_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .lcu_cnt_o    (lcu_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},  int'(busy_o), 0);
        chk({tag, "_start"}, int'(db_start_o), 0);
        chk({tag, "_ack"},   int'(lcu_ack_o), 0);
        chk({tag, "_fdone"}, int'(frame_done_o), 0);
        chk({tag, "_x"},     int'(lcu_x_o), 0);
        chk({tag, "_y"},     int'(lcu_y_o), 0);
        chk({tag, "_cnt"},   int'(lcu_cnt_o), 0);
        chk({tag, "_left"},  int'(lcu_left_o), 1);
        chk({tag, "_top"},   int'(lcu_top_o), 1);
    endtask

    // Model: raster-order LCU list plus the documented cycle latencies.
    task automatic run_frame(input int w, input int h, input int rdy_pct, input int bsy_pct,
                             input int hold_lo, input bit spur, input int abort_after);
        int  exp_x[$];
        int  exp_y[$];
        int  total, started, fd_cycle, done_at, wake, start_cyc, c0, budget;
        bit  waiting, exp_start, go;
        total = w * h;
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                exp_x.push_back(xx);
                exp_y.push_back(yy);
            end
        started = 0; fd_cycle = -1; done_at = -1; wake = -1; start_cyc = -1;
        waiting = 1'b0; exp_start = 1'b0;
        sys_start_i = 1'b1;
        pic_w_lcu_i = LCU_AW'(w);
        pic_h_lcu_i = LCU_AW'(h);
        c0 = cyc;
        step();
        sys_start_i = 1'b0;
        if (total == 0) fd_cycle = c0 + 1;
        else waiting = 1'b1;
        budget = cyc + total * 40 + hold_lo + 50;
        while (fd_cycle < 0 || cyc <= fd_cycle + 1) begin
            if (cyc > budget) begin
                chk("timeout", 0, 1);
                return;
            end
            chk("db_start", int'(db_start_o), int'(exp_start));
            chk("lcu_ack", int'(lcu_ack_o), int'(exp_start));
            if (exp_start) begin
                chk("x",    int'(lcu_x_o), exp_x[0]);
                chk("y",    int'(lcu_y_o), exp_y[0]);
                chk("left", int'(lcu_left_o), int'(exp_x[0] == 0));
                chk("top",  int'(lcu_top_o), int'(exp_y[0] == 0));
                chk("cnt_at_start", int'(lcu_cnt_o), started);
                void'(exp_x.pop_front());
                void'(exp_y.pop_front());
                started++;
                start_cyc = cyc;
                done_at = cyc + int'($urandom_range(1, 10));
            end
            chk("frame_done", int'(frame_done_o), int'(cyc == fd_cycle));
            chk("busy", int'(busy_o), int'(fd_cycle < 0 || cyc <= fd_cycle));
            if (cyc == fd_cycle)
                chk("cnt_final", int'(lcu_cnt_o), total);

            if (abort_after > 0 && started == abort_after && cyc == start_cyc + 1) begin
                db_done_i = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_reset_values("abort");
                #2 rst_n = 1'b1;
                step();
                return;
            end

            if (cyc == wake) waiting = 1'b1;
            db_done_i = (cyc == done_at);
            if (cyc == done_at) begin
                if (started == total) fd_cycle = cyc + 2;
                else wake = cyc + 2;
            end
            if (spur && !db_done_i && (waiting || exp_start))
                db_done_i = ($urandom_range(0, 3) == 0);
            sys_start_i = 1'b0;
            if (spur && fd_cycle < 0 && $urandom_range(0, 5) == 0) begin
                sys_start_i = 1'b1;
                pic_w_lcu_i = LCU_AW'($urandom_range(0, 9));
                pic_h_lcu_i = LCU_AW'($urandom_range(0, 9));
            end
            lcu_rdy_i  = (cyc < c0 + hold_lo) ? 1'b0 : (int'($urandom_range(0, 99)) < rdy_pct);
            out_busy_i = (int'($urandom_range(0, 99)) < bsy_pct);
            go = waiting && lcu_rdy_i && !out_busy_i;
            if (go) waiting = 1'b0;
            exp_start = go;
            step();
        end
        sys_start_i = 1'b0;
        db_done_i   = 1'b0;
        if (total > 0) chk("all_issued", started, total);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        chk_reset_values("reset");
        rst_n = 1'b1;
        step();

        run_frame(2, 2, 100, 0, 0, 1'b0, 0);
        run_frame(3, 1, 100, 0, 20, 1'b0, 0);
        run_frame(3, 1, 60, 40, 0, 1'b0, 0);
        run_frame(3, 3, 100, 0, 0, 1'b1, 0);
        run_frame(0, 5, 100, 0, 0, 1'b0, 0);
        run_frame(4, 0, 100, 0, 0, 1'b0, 0);
        run_frame(2, 2, 100, 0, 0, 1'b0, 2);
        chk_reset_values("post_abort");
        run_frame(2, 2, 100, 0, 0, 1'b0, 0);
        run_frame(127, 1, 90, 10, 0, 1'b0, 0);
        for (int i = 0; i < 6; i++)
            run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                      int'($urandom_range(30, 100)), int'($urandom_range(0, 50)),
                      int'($urandom_range(0, 5)), 1'(i % 2), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
